styler_pipe: RTL and testbench

Pipelined, parametrised successor to the combinational character styler. It sits between the glyph ROM read and the pixel serialiser. Per accepted beat it takes one glyph scanline plus its cell attributes and returns the styled, inverted and mirrored scanline three stages later. Blink, cursor and faint phases are generated internally from a frame strobe instead of being driven externally.

---
 rtl/styler_pipe.sv | 335 +++++++++++++++++++++++++++++++++
 tb/tb_styler_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/styler_pipe.sv
// styler_pipe
// Three-stage pipelined character styler between the glyph ROM read and the
// pixel serialiser. Each accepted beat carries one glyph scanline plus the
// cell attributes; the styled, inverted and mirrored scanline leaves three
// cycles later. Blink, cursor and faint phases come from internal frame-strobe
// driven generators.
//
// Ports
//   clk          single clock, all state on the rising edge
//   resetN       asynchronous active-low reset (release expected synchronous to clk)
//   frameStart   one-cycle pulse per frame, advances the phase generators
//   inValid      input beat valid
//   inReady      input beat accepted when inValid & inReady
//   scanlineIn   row index within the glyph cell
//   bitmapIn     glyph row, MSB is the leftmost pixel
//   attr[18:0]   bold, faint, italic, reverseItalic, blink, alternate, inverse,
//                hidden, underline, doubleUnderline, dottedUnderline,
//                strikethru, doubleStrikethru, dottedStrikethru, overline,
//                doubleOverline, dottedOverline, xoffset, yoffset (bit0 first)
//   cfg[10:0]    xscale, yscale, xPreMirror, xPostMirror, yPreMirror,
//                yPostMirror, blinkEnable, lineEnable, cursorEnable,
//                cursorTop, cursorBottom (bit0 first)
//   outValid     output beat valid
//   outReady     downstream accepts when outValid & outReady
//   scanlineOut  bitmap row to fetch, registered alongside its beat
//   bitmapOut    styled row
//   phaseOut     {cursorPhase, blinkPhase, faintPhase}
module styler_pipe #(
   parameter int WIDTH         = 16,
   parameter int HEIGHT        = 16,
   parameter int BLINK_PERIOD  = 32,
   parameter int CURSOR_PERIOD = 16,
   localparam int SBITS        = $clog2(HEIGHT)
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             frameStart,
   input  logic             inValid,
   output logic             inReady,
   input  logic [SBITS-1:0] scanlineIn,
   input  logic [WIDTH-1:0] bitmapIn,
   input  logic [18:0]      attr,
   input  logic [10:0]      cfg,
   output logic             outValid,
   input  logic             outReady,
   output logic [SBITS-1:0] scanlineOut,
   output logic [WIDTH-1:0] bitmapOut,
   output logic [2:0]       phaseOut
);

   // attribute bit positions
   localparam int A_BOLD   = 0;
   localparam int A_FAINT  = 1;
   localparam int A_ITAL   = 2;
   localparam int A_RITAL  = 3;
   localparam int A_BLINK  = 4;
   localparam int A_ALT    = 5;
   localparam int A_INV    = 6;
   localparam int A_HIDDEN = 7;
   localparam int A_UL     = 8;
   localparam int A_DUL    = 9;
   localparam int A_DOTUL  = 10;
   localparam int A_ST     = 11;
   localparam int A_DST    = 12;
   localparam int A_DOTST  = 13;
   localparam int A_OL     = 14;
   localparam int A_DOL    = 15;
   localparam int A_DOTOL  = 16;
   localparam int A_XOFF   = 17;
   localparam int A_YOFF   = 18;

   // config bit positions
   localparam int C_XSCALE  = 0;
   localparam int C_YSCALE  = 1;
   localparam int C_XPRE    = 2;
   localparam int C_XPOST   = 3;
   localparam int C_YPRE    = 4;
   localparam int C_YPOST   = 5;
   localparam int C_BLINKEN = 6;
   localparam int C_LINEEN  = 7;
   localparam int C_CUREN   = 8;
   localparam int C_CURTOP  = 9;
   localparam int C_CURBOT  = 10;

   localparam logic [SBITS-1:0] ROW_HALF   = SBITS'(HEIGHT / 2);
   localparam logic [SBITS-1:0] ROW_UL     = SBITS'(HEIGHT - 3);
   localparam logic [SBITS-1:0] ROW_DUL    = SBITS'(HEIGHT - 1);
   localparam logic [SBITS-1:0] ROW_ST     = SBITS'(HEIGHT / 2 - 1);
   localparam logic [SBITS-1:0] ROW_DST_LO = SBITS'(HEIGHT / 2 - 2);
   localparam logic [SBITS-1:0] ROW_DST_HI = SBITS'(HEIGHT / 2);
   localparam logic [SBITS-1:0] ROW_OL     = '0;
   localparam logic [SBITS-1:0] ROW_DOL    = SBITS'(2);
   localparam logic [SBITS-1:0] ROW_CTOP   = SBITS'(3);
   localparam logic [SBITS-1:0] ROW_CBOT   = SBITS'(HEIGHT - 4);

   localparam logic [7:0] BLINK_LAST  = 8'(BLINK_PERIOD - 1);
   localparam logic [7:0] CURSOR_LAST = 8'(CURSOR_PERIOD - 1);

   // Flags needed by the invert stage; everything is resolved against the
   // phases sampled at accept time so later frame strobes cannot leak in.
   typedef struct packed {
      logic solid;
      logic faint;
      logic faint_ph;
      logic kill;
      logic invert;
      logic xpost;
   } late_t;

   typedef struct packed {
      logic  bold;
      logic  italic;
      logic  ritalic;
      logic  xoff;
      logic  xscale;
      logic  xpre;
      late_t late;
   } early_t;

   function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      for (int i = 0; i < WIDTH; i++) r[i] = b[WIDTH-1-i];
      return r;
   endfunction

   // Row quarter selects the slant; reverse italic mirrors the direction.
   function automatic logic [WIDTH-1:0] slant(input logic [WIDTH-1:0] b,
                                              input logic [1:0] q,
                                              input logic it,
                                              input logic rit);
      logic [WIDTH-1:0] r;
      r = b;
      if (it && !rit) begin
         case (q)
            2'd0:    r = b >> 2;
            2'd1:    r = b >> 1;
            2'd3:    r = b << 1;
            default: r = b;
         endcase
      end else if (rit && !it) begin
         case (q)
            2'd0:    r = b << 2;
            2'd1:    r = b << 1;
            2'd3:    r = b >> 1;
            default: r = b;
         endcase
      end
      return r;
   endfunction

   // Each pixel of the left half becomes two pixels across the full row.
   function automatic logic [WIDTH-1:0] dbl_left(input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      for (int i = 0; i < WIDTH / 2; i++) begin
         r[2*i]   = b[WIDTH/2 + i];
         r[2*i+1] = b[WIDTH/2 + i];
      end
      return r;
   endfunction

   // Phase 1 keeps even pixels (...0101), phase 0 keeps odd pixels (...1010).
   function automatic logic [WIDTH-1:0] faint_mask(input logic ph);
      logic [WIDTH-1:0] m;
      for (int i = 0; i < WIDTH; i++) m[i] = ph ^ 1'(i % 2);
      return m;
   endfunction

   // phase generators
   logic [7:0] blink_cnt_q, blink_cnt_d, cursor_cnt_q, cursor_cnt_d;
   logic       blink_ph_q, blink_ph_d, cursor_ph_q, cursor_ph_d;
   logic       faint_ph_q, faint_ph_d;

   // pipeline state
   logic             en;
   logic             vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d, vld_p3_q, vld_p3_d;
   logic [WIDTH-1:0] bmp_p1_q, bmp_p1_d, bmp_p2_q, bmp_p2_d, bmp_p3_q, bmp_p3_d;
   logic [SBITS-1:0] row_p1_q, row_p1_d;
   logic [SBITS-1:0] scan_p1_q, scan_p1_d, scan_p2_q, scan_p2_d, scan_p3_q, scan_p3_d;
   early_t           early_p1_q, early_p1_d;
   late_t            late_p2_q, late_p2_d;

   // stage-1 combinational terms
   logic [SBITS-1:0] s0, s1, s2, s3;
   logic             solid_hit, dot_hit, cursor_row, cursor_on, inv_eff, alt_eff;
   early_t           early_c;
   logic [WIDTH-1:0] sty_c, inv_c;

   assign en       = ~vld_p3_q | outReady;
   assign inReady  = en;
   assign outValid = vld_p3_q;
   assign bitmapOut   = bmp_p3_q;
   assign scanlineOut = scan_p3_q;
   assign phaseOut    = {cursor_ph_q, blink_ph_q, faint_ph_q};

   // Generators run off frameStart regardless of pipeline stalls.
   always_comb begin
      faint_ph_d   = faint_ph_q;
      blink_cnt_d  = blink_cnt_q;
      blink_ph_d   = blink_ph_q;
      cursor_cnt_d = cursor_cnt_q;
      cursor_ph_d  = cursor_ph_q;
      if (frameStart) begin
         faint_ph_d = ~faint_ph_q;
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 8'd1;
         end
         if (cursor_cnt_q == CURSOR_LAST) begin
            cursor_cnt_d = '0;
            cursor_ph_d  = ~cursor_ph_q;
         end else begin
            cursor_cnt_d = cursor_cnt_q + 8'd1;
         end
      end
   end

   // ---- stage 1: linegen ----
   always_comb begin
      s0 = scanlineIn;
      s1 = cfg[C_YPOST] ? ~s0 : s0;
      s2 = cfg[C_YSCALE] ? (s1 >> 1) : s1;
      s3 = attr[A_YOFF] ? (s2 ^ ROW_HALF) : s2;

      solid_hit = (attr[A_UL]  && s3 == ROW_UL)
               || (attr[A_DUL] && (s3 == ROW_UL || s3 == ROW_DUL))
               || (attr[A_ST]  && s3 == ROW_ST)
               || (attr[A_DST] && (s3 == ROW_DST_LO || s3 == ROW_DST_HI))
               || (attr[A_OL]  && s3 == ROW_OL)
               || (attr[A_DOL] && (s3 == ROW_OL || s3 == ROW_DOL));
      // A dotted line is drawn solid and then thinned by the faint mask.
      dot_hit   = (attr[A_DOTUL] && s3 == ROW_UL)
               || (attr[A_DOTST] && s3 == ROW_ST)
               || (attr[A_DOTOL] && s3 == ROW_OL);

      cursor_row = (cfg[C_CURTOP] && s0 < ROW_CTOP)
                || (cfg[C_CURBOT] && s0 > ROW_CBOT)
                || (!cfg[C_CURTOP] && !cfg[C_CURBOT]);
      cursor_on  = cfg[C_CUREN] & cursor_ph_q & cursor_row;
      inv_eff    = attr[A_INV] ^ cursor_on;
      alt_eff    = attr[A_ALT] & (blink_ph_q | ~cfg[C_BLINKEN]);

      early_c               = '0;
      early_c.bold          = attr[A_BOLD];
      early_c.italic        = attr[A_ITAL];
      early_c.ritalic       = attr[A_RITAL];
      early_c.xoff          = attr[A_XOFF];
      early_c.xscale        = cfg[C_XSCALE];
      early_c.xpre          = cfg[C_XPRE];
      early_c.late.solid    = cfg[C_LINEEN] & (solid_hit | dot_hit);
      early_c.late.faint    = attr[A_FAINT] | (cfg[C_LINEEN] & dot_hit);
      early_c.late.faint_ph = faint_ph_q ^ s1[0];
      early_c.late.kill     = attr[A_HIDDEN] | (attr[A_BLINK] & blink_ph_q & cfg[C_BLINKEN]);
      // alternate and inverse each invert once, so together they cancel
      early_c.late.invert   = alt_eff ^ inv_eff;
      early_c.late.xpost    = cfg[C_XPOST];

      vld_p1_d   = en ? inValid  : vld_p1_q;
      bmp_p1_d   = en ? bitmapIn : bmp_p1_q;
      row_p1_d   = en ? s3       : row_p1_q;
      scan_p1_d  = en ? (cfg[C_YPRE] ? ~s3 : s3) : scan_p1_q;
      early_p1_d = en ? early_c  : early_p1_q;
   end

   // ---- stage 2: style ----
   always_comb begin
      sty_c = bmp_p1_q;
      if (early_p1_q.xpre) sty_c = bit_rev(sty_c);
      sty_c = slant(sty_c, row_p1_q[SBITS-1 -: 2], early_p1_q.italic, early_p1_q.ritalic);
      if (early_p1_q.bold) sty_c = sty_c | (sty_c >> 1);
      if (early_p1_q.xoff) sty_c = {sty_c[WIDTH/2-1:0], sty_c[WIDTH-1:WIDTH/2]};
      if (early_p1_q.xscale) sty_c = dbl_left(sty_c);
      if (early_p1_q.late.solid) sty_c = '1;
      if (early_p1_q.late.faint) sty_c = sty_c & faint_mask(early_p1_q.late.faint_ph);

      vld_p2_d  = en ? vld_p1_q        : vld_p2_q;
      bmp_p2_d  = en ? sty_c           : bmp_p2_q;
      scan_p2_d = en ? scan_p1_q       : scan_p2_q;
      late_p2_d = en ? early_p1_q.late : late_p2_q;
   end

   // ---- stage 3: invert ----
   always_comb begin
      inv_c = bmp_p2_q;
      if (late_p2_q.solid) inv_c = '1;
      if (late_p2_q.faint) inv_c = inv_c & faint_mask(late_p2_q.faint_ph);
      if (late_p2_q.kill) inv_c = '0;
      if (late_p2_q.invert) inv_c = ~inv_c;
      if (late_p2_q.xpost) inv_c = bit_rev(inv_c);

      vld_p3_d  = en ? vld_p2_q  : vld_p3_q;
      bmp_p3_d  = en ? inv_c     : bmp_p3_q;
      scan_p3_d = en ? scan_p2_q : scan_p3_q;
   end

   // Control, generators and the visible output register clear on reset.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         vld_p1_q     <= 1'b0;
         vld_p2_q     <= 1'b0;
         vld_p3_q     <= 1'b0;
         bmp_p3_q     <= '0;
         scan_p3_q    <= '0;
         faint_ph_q   <= 1'b0;
         blink_cnt_q  <= '0;
         blink_ph_q   <= 1'b0;
         cursor_cnt_q <= '0;
         cursor_ph_q  <= 1'b0;
      end else begin
         vld_p1_q     <= vld_p1_d;
         vld_p2_q     <= vld_p2_d;
         vld_p3_q     <= vld_p3_d;
         bmp_p3_q     <= bmp_p3_d;
         scan_p3_q    <= scan_p3_d;
         faint_ph_q   <= faint_ph_d;
         blink_cnt_q  <= blink_cnt_d;
         blink_ph_q   <= blink_ph_d;
         cursor_cnt_q <= cursor_cnt_d;
         cursor_ph_q  <= cursor_ph_d;
      end
   end

   // Internal data is qualified by the valids and needs no reset.
   always_ff @(posedge clk) begin
      bmp_p1_q   <= bmp_p1_d;
      row_p1_q   <= row_p1_d;
      scan_p1_q  <= scan_p1_d;
      early_p1_q <= early_p1_d;
      bmp_p2_q   <= bmp_p2_d;
      scan_p2_q  <= scan_p2_d;
      late_p2_q  <= late_p2_d;
   end

endmodule

// File: tb/tb_styler_pipe.sv
// Directed bench for styler_pipe (WIDTH=16, HEIGHT=16, BLINK_PERIOD=2,
// CURSOR_PERIOD=3). A vector table covers single-beat styling; hand-written
// sequences cover latency, stall, blink phasing and mid-stream reset.
module tb_styler_pipe;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        frameStart = 1'b0;
   logic        inValid = 1'b0;
   logic        inReady;
   logic [3:0]  scanlineIn = '0;
   logic [15:0] bitmapIn = '0;
   logic [18:0] attr = '0;
   logic [10:0] cfg = '0;
   logic        outValid;
   logic        outReady = 1'b1;
   logic [3:0]  scanlineOut;
   logic [15:0] bitmapOut;
   logic [2:0]  phaseOut;

   int n_tests = 0;
   int n_fail  = 0;

   styler_pipe #(
      .WIDTH(16), .HEIGHT(16), .BLINK_PERIOD(2), .CURSOR_PERIOD(3)
   ) dut (
      .clk(clk), .resetN(resetN), .frameStart(frameStart),
      .inValid(inValid), .inReady(inReady),
      .scanlineIn(scanlineIn), .bitmapIn(bitmapIn), .attr(attr), .cfg(cfg),
      .outValid(outValid), .outReady(outReady),
      .scanlineOut(scanlineOut), .bitmapOut(bitmapOut), .phaseOut(phaseOut)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      int          nfr;
      logic [3:0]  scan;
      logic [15:0] bmp;
      logic [18:0] at;
      logic [10:0] cf;
      logic [15:0] eb;
      logic [3:0]  es;
   } vec_t;

   vec_t vt[$];

   function automatic void add(int nfr, logic [3:0] s, logic [15:0] b, logic [18:0] a,
                               logic [10:0] c, logic [15:0] eb, logic [3:0] es);
      vec_t v;
      v.nfr = nfr; v.scan = s; v.bmp = b; v.at = a; v.cf = c; v.eb = eb; v.es = es;
      vt.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic frame_pulse();
      @(negedge clk); frameStart = 1'b1;
      @(negedge clk); frameStart = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk); resetN = 1'b0; inValid = 1'b0; frameStart = 1'b0; outReady = 1'b1;
      repeat (2) @(negedge clk);
      resetN = 1'b1;
   endtask

   // Present one beat (optionally with frameStart in the same cycle) and
   // wait a bounded number of cycles for it to emerge.
   task automatic run_beat(input logic [3:0] s, input logic [15:0] b, input logic [18:0] a,
                           input logic [10:0] c, input logic fs,
                           output logic [15:0] ob, output logic [3:0] os, output int lat);
      @(negedge clk);
      scanlineIn = s; bitmapIn = b; attr = a; cfg = c; inValid = 1'b1; frameStart = fs;
      lat = -1; ob = 'x; os = 'x;
      for (int k = 1; k <= 10 && lat < 0; k++) begin
         @(negedge clk);
         inValid = 1'b0; frameStart = 1'b0;
         #1;
         if (outValid) begin
            lat = k; ob = bitmapOut; os = scanlineOut;
         end
      end
   endtask

   logic [15:0] ob;
   logic [3:0]  os;
   int          lat;
   logic [15:0] bd [4];
   logic [15:0] got [8];
   int          ng;
   int          seen;
   logic [15:0] blink_exp [4];

   initial begin
      // phase-0 vectors: faintPhase=0, blinkPhase=0, cursorPhase=0
      add(0, 4'd5,  16'h1234, 19'h00000, 11'h000, 16'h1234, 4'd5);
      add(0, 4'd13, 16'h0000, 19'h00100, 11'h080, 16'hFFFF, 4'd13);
      add(0, 4'd13, 16'h0000, 19'h00400, 11'h080, 16'h5555, 4'd13);
      add(0, 4'd0,  16'h8000, 19'h00004, 11'h000, 16'h2000, 4'd0);
      add(0, 4'd15, 16'h8000, 19'h00004, 11'h000, 16'h0000, 4'd15);
      add(0, 4'd0,  16'h0001, 19'h00008, 11'h000, 16'h0004, 4'd0);
      add(0, 4'd0,  16'h8000, 19'h0000C, 11'h000, 16'h8000, 4'd0);
      add(0, 4'd5,  16'h1234, 19'h00001, 11'h000, 16'h1B3E, 4'd5);
      add(0, 4'd5,  16'h1234, 19'h20000, 11'h000, 16'h3412, 4'd5);
      add(0, 4'd5,  16'h1234, 19'h00000, 11'h001, 16'h030C, 4'd5);
      add(0, 4'd5,  16'h1234, 19'h00000, 11'h004, 16'h2C48, 4'd5);
      add(0, 4'd5,  16'h1234, 19'h00000, 11'h008, 16'h2C48, 4'd5);
      add(0, 4'd0,  16'h0001, 19'h00004, 11'h004, 16'h2000, 4'd0);
      add(0, 4'd0,  16'h0001, 19'h00004, 11'h008, 16'h0000, 4'd0);
      add(0, 4'd5,  16'h1234, 19'h00040, 11'h000, 16'hEDCB, 4'd5);
      add(0, 4'd5,  16'h1234, 19'h00080, 11'h000, 16'h0000, 4'd5);
      add(0, 4'd5,  16'h1234, 19'h000C0, 11'h000, 16'hFFFF, 4'd5);
      add(0, 4'd5,  16'h1234, 19'h00020, 11'h000, 16'hEDCB, 4'd5);
      add(0, 4'd5,  16'h1234, 19'h00020, 11'h040, 16'h1234, 4'd5);
      add(0, 4'd5,  16'h1234, 19'h00010, 11'h040, 16'h1234, 4'd5);
      add(0, 4'd5,  16'hFFFF, 19'h00002, 11'h000, 16'h5555, 4'd5);
      add(0, 4'd4,  16'hFFFF, 19'h00002, 11'h000, 16'hAAAA, 4'd4);
      add(0, 4'd5,  16'h1234, 19'h00000, 11'h020, 16'h1234, 4'd10);
      add(0, 4'd5,  16'h1234, 19'h00000, 11'h010, 16'h1234, 4'd10);
      add(0, 4'd2,  16'h0000, 19'h00100, 11'h0A0, 16'hFFFF, 4'd13);
      add(0, 4'd2,  16'h0000, 19'h00100, 11'h090, 16'h0000, 4'd13);
      add(0, 4'd9,  16'h1234, 19'h00000, 11'h002, 16'h1234, 4'd4);
      add(0, 4'd3,  16'h1234, 19'h40000, 11'h000, 16'h1234, 4'd11);
      add(0, 4'd7,  16'h0000, 19'h00800, 11'h080, 16'hFFFF, 4'd7);
      add(0, 4'd7,  16'h1234, 19'h00800, 11'h000, 16'h1234, 4'd7);
      add(0, 4'd8,  16'h0000, 19'h01000, 11'h080, 16'hFFFF, 4'd8);
      add(0, 4'd6,  16'h0000, 19'h01000, 11'h080, 16'hFFFF, 4'd6);
      add(0, 4'd7,  16'h0000, 19'h01000, 11'h080, 16'h0000, 4'd7);
      add(0, 4'd0,  16'h0000, 19'h04000, 11'h080, 16'hFFFF, 4'd0);
      add(0, 4'd2,  16'h0000, 19'h08000, 11'h080, 16'hFFFF, 4'd2);
      add(0, 4'd2,  16'h0000, 19'h04000, 11'h080, 16'h0000, 4'd2);
      add(0, 4'd15, 16'h0000, 19'h00200, 11'h080, 16'hFFFF, 4'd15);
      add(0, 4'd7,  16'h0000, 19'h02000, 11'h080, 16'h5555, 4'd7);
      add(0, 4'd0,  16'h0000, 19'h10000, 11'h080, 16'hAAAA, 4'd0);
      add(0, 4'd5,  16'h1234, 19'h00000, 11'h100, 16'h1234, 4'd5);
      // three frames: faintPhase=1, blinkPhase=1, cursorPhase=1
      add(3, 4'd5,  16'h1234, 19'h00000, 11'h100, 16'hEDCB, 4'd5);
      add(0, 4'd5,  16'h1234, 19'h00000, 11'h300, 16'h1234, 4'd5);
      add(0, 4'd2,  16'h1234, 19'h00000, 11'h300, 16'hEDCB, 4'd2);
      add(0, 4'd13, 16'h1234, 19'h00000, 11'h500, 16'hEDCB, 4'd13);
      add(0, 4'd12, 16'h1234, 19'h00000, 11'h500, 16'h1234, 4'd12);
      add(0, 4'd5,  16'h1234, 19'h00010, 11'h040, 16'h0000, 4'd5);
      add(0, 4'd5,  16'h1234, 19'h00020, 11'h040, 16'hEDCB, 4'd5);
      add(0, 4'd5,  16'h1234, 19'h00040, 11'h100, 16'h1234, 4'd5);
      add(0, 4'd5,  16'hFFFF, 19'h00002, 11'h000, 16'hAAAA, 4'd5);

      // reset state
      repeat (3) @(negedge clk);
      resetN = 1'b1;
      #1;
      check("reset_outvalid", outValid, 0);
      check("reset_bitmap", bitmapOut, 0);
      check("reset_scanline", scanlineOut, 0);
      check("reset_phase", phaseOut, 0);
      check("reset_inready", inReady, 1);

      // table
      for (int i = 0; i < vt.size(); i++) begin
         repeat (vt[i].nfr) frame_pulse();
         run_beat(vt[i].scan, vt[i].bmp, vt[i].at, vt[i].cf, 1'b0, ob, os, lat);
         check($sformatf("vec%0d_latency", i), lat, 3);
         check($sformatf("vec%0d_bitmap", i), ob, vt[i].eb);
         check($sformatf("vec%0d_scanline", i), os, vt[i].es);
      end
      #1;
      check("phase_after_3_frames", phaseOut, 3'b111);

      // 4-beat burst with a 5-cycle stall starting at the second output
      do_reset();
      bd[0] = 16'hA1A1; bd[1] = 16'hB2B2; bd[2] = 16'hC3C3; bd[3] = 16'hD4D4;
      for (int i = 0; i < 8; i++) got[i] = '0;
      ng = 0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         inValid = (c < 4); bitmapIn = bd[c % 4]; scanlineIn = 4'(c);
         attr = '0; cfg = '0;
         outReady = !(c >= 4 && c < 9);
         #1;
         if (c >= 4 && c < 9) begin
            check($sformatf("stall%0d_inready", c), inReady, 0);
            check($sformatf("stall%0d_outvalid", c), outValid, 1);
            check($sformatf("stall%0d_hold", c), bitmapOut, bd[1]);
         end
         if (outValid && outReady) begin
            if (ng < 8) got[ng] = bitmapOut;
            ng++;
         end
      end
      inValid = 1'b0; outReady = 1'b1;
      check("burst_count", ng, 4);
      for (int i = 0; i < 4; i++) check($sformatf("burst_order%0d", i), got[i], bd[i]);

      // blink phase sampled with the beat, pre-update
      do_reset();
      blink_exp[0] = 16'hFFFF; blink_exp[1] = 16'hFFFF;
      blink_exp[2] = 16'h0000; blink_exp[3] = 16'h0000;
      for (int k = 0; k < 4; k++) begin
         run_beat(4'd5, 16'hFFFF, 19'h00010, 11'h040, 1'b1, ob, os, lat);
         check($sformatf("blink%0d_latency", k), lat, 3);
         check($sformatf("blink%0d_bitmap", k), ob, blink_exp[k]);
      end
      #1;
      check("phase_after_blink_seq", phaseOut, 3'b100);

      // reset with beats in flight
      frame_pulse();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         inValid = 1'b1; bitmapIn = 16'h0F0F; scanlineIn = 4'(c); attr = '0; cfg = '0;
      end
      @(negedge clk);
      inValid = 1'b0; resetN = 1'b0;
      #1;
      check("midrst_outvalid", outValid, 0);
      check("midrst_phase", phaseOut, 0);
      check("midrst_bitmap", bitmapOut, 0);
      repeat (2) @(negedge clk);
      resetN = 1'b1;
      #1;
      check("midrst_inready", inReady, 1);
      seen = 0;
      repeat (8) begin
         @(negedge clk); #1;
         if (outValid) seen++;
      end
      check("midrst_no_output", seen, 0);
      run_beat(4'd5, 16'h1234, 19'h00000, 11'h000, 1'b0, ob, os, lat);
      check("midrst_next_latency", lat, 3);
      check("midrst_next_bitmap", ob, 16'h1234);
      check("midrst_next_scanline", os, 4'd5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
